// File: rtl/mp_mac_array_pkg.sv
// Shared precision codes, mode encoding and helpers for the multi-precision MAC array.
package mp_mac_pkg;

   localparam logic [1:0] CONV_2 = 2'b01;
   localparam logic [1:0] CONV_4 = 2'b10;
   localparam logic [1:0] CONV_8 = 2'b11;

   localparam int LANE_W = 18;

   typedef enum logic [2:0] {
      M8x8,
      M8x4,
      M8x2,
      M4x4,
      M4x2,
      M2x2
   } mode_t;

   function automatic int pd_of(input mode_t m);
      case (m)
         M8x8, M8x4, M8x2: return 8;
         M4x4, M4x2:       return 4;
         default:          return 2;
      endcase
   endfunction

   function automatic int pw_of(input mode_t m);
      case (m)
         M8x8:             return 8;
         M8x4, M4x4:       return 4;
         default:          return 2;
      endcase
   endfunction

   // Codes are ordered by width, so comparing them compares precisions.
   function automatic logic mode_legal(input logic [1:0] cd, input logic [1:0] cw);
      return (cd != 2'b00) && (cw != 2'b00) && (cw <= cd);
   endfunction

   function automatic mode_t mode_decode(input logic [1:0] cd, input logic [1:0] cw);
      mode_t m;
      m = M2x2;
      if (mode_legal(cd, cw)) begin
         case ({cd, cw})
            {CONV_8, CONV_8}: m = M8x8;
            {CONV_8, CONV_4}: m = M8x4;
            {CONV_8, CONV_2}: m = M8x2;
            {CONV_4, CONV_4}: m = M4x4;
            {CONV_4, CONV_2}: m = M4x2;
            default:          m = M2x2;
         endcase
      end
      return m;
   endfunction

endpackage

// File: rtl/mp_mac_array_if.sv
// Beat input stream and result output stream of the MAC array.
interface mp_mac_array_if #(
   parameter int LANES = 4,
   parameter int ACC_W = 32
);
   logic                    in_valid;
   logic                    in_ready;
   logic                    in_last;
   logic [1:0]              convtypeD;
   logic [1:0]              convtypeW;
   logic [8*LANES-1:0]      d;
   logic [8*LANES-1:0]      w;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [ACC_W-1:0] out_acc;
   logic                    out_err;
   logic                    out_sat;

   modport master (
      output in_valid, in_last, convtypeD, convtypeW, d, w, out_ready,
      input  in_ready, out_valid, out_acc, out_err, out_sat
   );

   modport slave (
      input  in_valid, in_last, convtypeD, convtypeW, d, w, out_ready,
      output in_ready, out_valid, out_acc, out_err, out_sat
   );
endinterface

// File: rtl/mp_mac_array_lane_mul.sv
// One lane: unsigned data slots times signed weight slots, summed to an 18-bit lane total.
module mp_lane_mul
   import mp_mac_pkg::*;
(
   input  logic [7:0]               d,
   input  logic [7:0]               w,
   input  mode_t                    mode,
   output logic signed [LANE_W-1:0] sum
);

   int                       pd;
   int                       pw;
   int                       slots;
   logic [7:0]               d_sh;
   logic [7:0]               w_sh;
   logic [7:0]               d_slot;
   logic signed [7:0]        w_slot;
   logic signed [LANE_W-1:0] prod;

   always_comb begin
      pd     = pd_of(mode);
      pw     = pw_of(mode);
      slots  = (pd == 8) ? 1 : ((pd == 4) ? 2 : 4);
      sum    = '0;
      d_sh   = '0;
      w_sh   = '0;
      d_slot = '0;
      w_slot = '0;
      prod   = '0;
      for (int j = 0; j < 4; j++) begin
         d_sh = d >> (pd * j);
         w_sh = w >> (pd * j);
         case (pd)
            8:       d_slot = d_sh;
            4:       d_slot = {4'b0, d_sh[3:0]};
            default: d_slot = {6'b0, d_sh[1:0]};
         endcase
         // Weight uses only the low Pw bits of its slot; the rest are ignored.
         case (pw)
            8:       w_slot = w_sh;
            4:       w_slot = {{4{w_sh[3]}}, w_sh[3:0]};
            default: w_slot = {{6{w_sh[1]}}, w_sh[1:0]};
         endcase
         prod = $signed({10'b0, d_slot}) * LANE_W'(w_slot);
         if (j < slots) sum = sum + prod;
      end
   end

endmodule

// File: rtl/mp_mac_array.sv
// Pipelined multi-precision MAC array: per-lane products, cross-lane sum, framed accumulation.
//
//   state   | meaning
//   FR_IDLE | next accepted beat starts a frame and latches its mode
//   FR_BUSY | inside a frame; beats accumulate using the latched mode
module mp_mac_array
   import mp_mac_pkg::*;
#(
   parameter int LANES    = 4,
   parameter int ACC_W    = 32,
   parameter int SATURATE = 1
) (
   input  logic          clk,
   input  logic          rst,
   mp_mac_array_if.slave bus
);

   localparam int TREE_W = LANE_W + $clog2(LANES);
   localparam int EXT_W  = ((ACC_W > TREE_W) ? ACC_W : TREE_W) + 1;
   localparam logic signed [EXT_W-1:0] ACC_MAX = EXT_W'({1'b0, {(ACC_W-1){1'b1}}});
   localparam logic signed [EXT_W-1:0] ACC_MIN = ~ACC_MAX;

   typedef enum logic {FR_IDLE, FR_BUSY} frame_t;

   frame_t                   fr_state;
   frame_t                   fr_next;
   logic                     stall;
   logic                     accept;
   logic [3:0]               frame_codes;
   mode_t                    frame_mode;
   mode_t                    beat_mode;
   logic                     beat_err;

   logic                     v1, first1, last1, err1;
   mode_t                    mode1;
   logic [8*LANES-1:0]       d1, w1;

   logic                     v2, first2, last2, err2;
   logic signed [LANE_W-1:0] lane_sum   [LANES];
   logic signed [LANE_W-1:0] lane_sum_q [LANES];

   logic signed [TREE_W-1:0] tree_sum;
   logic signed [EXT_W-1:0]  acc_full;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  acc_next;
   logic                     err_acc, sat_acc, err_next, sat_next, sat_now;

   assign stall       = bus.out_valid && !bus.out_ready;
   assign bus.in_ready = !stall;
   assign accept      = bus.in_valid && !stall;

   always_ff @(posedge clk) begin
      if (rst) fr_state <= FR_IDLE;
      else     fr_state <= fr_next;
   end

   always_comb begin
      fr_next   = fr_state;
      beat_mode = frame_mode;
      beat_err  = 1'b0;
      case (fr_state)
         FR_IDLE: begin
            beat_mode = mode_decode(bus.convtypeD, bus.convtypeW);
            beat_err  = !mode_legal(bus.convtypeD, bus.convtypeW);
            if (accept && !bus.in_last) fr_next = FR_BUSY;
         end
         FR_BUSY: begin
            beat_err = ({bus.convtypeD, bus.convtypeW} != frame_codes);
            if (accept && bus.in_last) fr_next = FR_IDLE;
         end
         default: fr_next = FR_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_codes <= '0;
         frame_mode  <= M2x2;
      end else if (accept && fr_state == FR_IDLE) begin
         frame_codes <= {bus.convtypeD, bus.convtypeW};
         frame_mode  <= beat_mode;
      end
   end

   // S1: registered beat with its resolved mode and framing flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1     <= 1'b0;
         first1 <= 1'b0;
         last1  <= 1'b0;
         err1   <= 1'b0;
         mode1  <= M2x2;
         d1     <= '0;
         w1     <= '0;
      end else if (!stall) begin
         v1     <= bus.in_valid;
         first1 <= (fr_state == FR_IDLE);
         last1  <= bus.in_last;
         err1   <= beat_err;
         mode1  <= beat_mode;
         d1     <= bus.d;
         w1     <= bus.w;
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      mp_lane_mul u_mul (
         .d    (d1[8*i +: 8]),
         .w    (w1[8*i +: 8]),
         .mode (mode1),
         .sum  (lane_sum[i])
      );
   end

   // S2: per-lane sums.
   always_ff @(posedge clk) begin
      if (rst) begin
         v2         <= 1'b0;
         first2     <= 1'b0;
         last2      <= 1'b0;
         err2       <= 1'b0;
         lane_sum_q <= '{default: '0};
      end else if (!stall) begin
         v2         <= v1;
         first2     <= first1;
         last2      <= last1;
         err2       <= err1;
         lane_sum_q <= lane_sum;
      end
   end

   // S3: cross-lane sum and accumulate; first beat of a frame loads instead of adding.
   always_comb begin
      tree_sum = '0;
      for (int i = 0; i < LANES; i++) tree_sum = tree_sum + TREE_W'(lane_sum_q[i]);
      acc_full = first2 ? EXT_W'(tree_sum) : (EXT_W'(acc) + EXT_W'(tree_sum));
      acc_next = ACC_W'(acc_full);
      sat_now  = 1'b0;
      if (SATURATE != 0) begin
         if (acc_full > ACC_MAX) begin
            acc_next = ACC_W'(ACC_MAX);
            sat_now  = 1'b1;
         end else if (acc_full < ACC_MIN) begin
            acc_next = ACC_W'(ACC_MIN);
            sat_now  = 1'b1;
         end
      end
      err_next = (first2 ? 1'b0 : err_acc) | err2;
      sat_next = (first2 ? 1'b0 : sat_acc) | sat_now;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc           <= '0;
         err_acc       <= 1'b0;
         sat_acc       <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_acc   <= '0;
         bus.out_err   <= 1'b0;
         bus.out_sat   <= 1'b0;
      end else begin
         if (v2 && !stall) begin
            acc     <= acc_next;
            err_acc <= err_next;
            sat_acc <= sat_next;
         end
         if (v2 && last2 && !stall) begin
            bus.out_valid <= 1'b1;
            bus.out_acc   <= acc_next;
            bus.out_err   <= err_next;
            bus.out_sat   <= sat_next;
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mp_mac_array.sv
// Scoreboard bench: saturating and wrapping instances share stimulus, checked against a frame model.
module tb_mp_mac_array;

   localparam int LANES = 4;
   localparam int ACC_W = 18;
   localparam int DW    = 8 * LANES;
   localparam longint AMAX = (longint'(1) << (ACC_W - 1)) - 1;
   localparam longint AMIN = -AMAX - 1;

   typedef struct {
      longint acc_s;
      longint acc_w;
      longint err;
      longint sat;
   } exp_t;

   exp_t   sb[$];
   int     n_vec  = 0;
   int     n_fail = 0;
   logic   clk    = 1'b0;
   logic   rst    = 1'b1;
   int     ready_mode = 0;

   bit         m_in_frame = 0;
   logic [3:0] m_codes    = '0;
   int         m_pd = 2, m_pw = 2;
   longint     m_acc_s = 0, m_acc_w = 0;
   bit         m_err = 0, m_sat = 0;

   always #5 clk = ~clk;

   mp_mac_array_if #(.LANES(LANES), .ACC_W(ACC_W)) bus_s ();
   mp_mac_array_if #(.LANES(LANES), .ACC_W(ACC_W)) bus_w ();

   assign bus_w.in_valid  = bus_s.in_valid;
   assign bus_w.in_last   = bus_s.in_last;
   assign bus_w.convtypeD = bus_s.convtypeD;
   assign bus_w.convtypeW = bus_s.convtypeW;
   assign bus_w.d         = bus_s.d;
   assign bus_w.w         = bus_s.w;
   assign bus_w.out_ready = bus_s.out_ready;

   mp_mac_array #(.LANES(LANES), .ACC_W(ACC_W), .SATURATE(1)) u_sat (
      .clk (clk), .rst (rst), .bus (bus_s));
   mp_mac_array #(.LANES(LANES), .ACC_W(ACC_W), .SATURATE(0)) u_wrap (
      .clk (clk), .rst (rst), .bus (bus_w));

   function automatic void chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic int prec_bits(input logic [1:0] c);
      case (c)
         2'b01:   return 2;
         2'b10:   return 4;
         2'b11:   return 8;
         default: return 0;
      endcase
   endfunction

   // Dot product of one beat: every lane, every slot, unsigned data times signed weight.
   function automatic longint beat_value(input int pd, input int pw,
                                         input logic [DW-1:0] dv, input logic [DW-1:0] wv);
      longint s;
      logic [DW-1:0] td, tw;
      int dd, ww, sh;
      s = 0;
      for (int l = 0; l < LANES; l++) begin
         for (int j = 0; j < 8 / pd; j++) begin
            sh = 8 * l + pd * j;
            td = dv >> sh;
            tw = wv >> sh;
            dd = int'(td[7:0]) & ((1 << pd) - 1);
            ww = int'(tw[7:0]) & ((1 << pw) - 1);
            if (ww >= (1 << (pw - 1))) ww = ww - (1 << pw);
            s = s + longint'(dd * ww);
         end
      end
      return s;
   endfunction

   function automatic longint wrapv(input longint x);
      longint m, r;
      m = longint'(1) << ACC_W;
      r = x % m;
      if (r < 0) r = r + m;
      if (r > AMAX) r = r - m;
      return r;
   endfunction

   function automatic void model_beat(input logic [1:0] cd, input logic [1:0] cw,
                                      input logic [DW-1:0] dv, input logic [DW-1:0] wv,
                                      input logic last);
      longint b, s;
      int pd, pw;
      if (!m_in_frame) begin
         pd = prec_bits(cd);
         pw = prec_bits(cw);
         if (pd == 0 || pw == 0 || pw > pd) begin
            m_pd = 2; m_pw = 2; m_err = 1;
         end else begin
            m_pd = pd; m_pw = pw; m_err = 0;
         end
         m_codes = {cd, cw};
         m_sat   = 0;
         b       = beat_value(m_pd, m_pw, dv, wv);
         s       = b;
         m_acc_w = wrapv(b);
      end else begin
         if ({cd, cw} != m_codes) m_err = 1;
         b       = beat_value(m_pd, m_pw, dv, wv);
         s       = m_acc_s + b;
         m_acc_w = wrapv(m_acc_w + b);
      end
      if (s > AMAX) begin
         s = AMAX; m_sat = 1;
      end else if (s < AMIN) begin
         s = AMIN; m_sat = 1;
      end
      m_acc_s    = s;
      m_in_frame = !last;
      if (last) sb.push_back('{m_acc_s, m_acc_w, longint'(m_err), longint'(m_sat)});
   endfunction

   task automatic send(input logic [1:0] cd, input logic [1:0] cw,
                       input logic [DW-1:0] dv, input logic [DW-1:0] wv, input logic last);
      bit ok;
      ok = 0;
      bus_s.in_valid  = 1'b1;
      bus_s.in_last   = last;
      bus_s.convtypeD = cd;
      bus_s.convtypeW = cw;
      bus_s.d         = dv;
      bus_s.w         = wv;
      for (int k = 0; k < 2000 && !ok; k++) begin
         @(negedge clk);
         ok = bus_s.in_ready;
         @(posedge clk);
      end
      if (ok) model_beat(cd, cw, dv, wv, last);
      else chk("send_timeout", 0, 1);
      #1;
      bus_s.in_valid = 1'b0;
      bus_s.in_last  = 1'b0;
   endtask

   task automatic bubble(input int n);
      bus_s.in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int k = 0; k < 1000 && sb.size() > 0; k++) @(negedge clk);
      if (sb.size() > 0) chk("drain_timeout", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] rep(input logic [7:0] b);
      logic [DW-1:0] v;
      for (int l = 0; l < LANES; l++) v[8*l +: 8] = b;
      return v;
   endfunction

   task automatic rand_frame();
      int len;
      bit extreme;
      logic [1:0] cd, cw, bcd, bcw;
      logic [DW-1:0] dv, wv;
      len     = $urandom_range(1, 5);
      extreme = ($urandom_range(0, 4) == 0);
      cd = 2'($urandom_range(1, 3));
      cw = 2'($urandom_range(1, int'(cd)));
      if ($urandom_range(0, 9) == 0) begin
         cd = 2'($urandom_range(0, 3));
         cw = 2'($urandom_range(0, 3));
      end
      if (extreme) begin
         cd = 2'b11; cw = 2'b11;
         if (len < 2) len = 2;
      end
      for (int b = 0; b < len; b++) begin
         for (int l = 0; l < LANES; l++) begin
            dv[8*l +: 8] = 8'($urandom);
            wv[8*l +: 8] = 8'($urandom);
         end
         if (extreme) begin
            dv = rep(8'hFF);
            wv = ($urandom_range(0, 1) == 1) ? rep(8'h80) : rep(8'h7F);
         end
         bcd = cd; bcw = cw;
         if (b > 0 && $urandom_range(0, 9) == 0) begin
            bcd = 2'($urandom_range(0, 3));
            bcw = 2'($urandom_range(0, 3));
         end
         send(bcd, bcw, dv, wv, (b == len - 1));
         if ($urandom_range(0, 3) == 0) bubble($urandom_range(1, 3));
      end
   endtask

   initial begin
      bus_s.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       bus_s.out_ready = 1'b1;
            2:       bus_s.out_ready = 1'b0;
            default: bus_s.out_ready = ($urandom_range(0, 9) < 7);
         endcase
      end
   end

   // Monitor: compares every presented result with the head of the scoreboard.
   initial begin
      int   idle;
      exp_t e;
      idle = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("in_ready", longint'(bus_s.in_ready),
                longint'(!(bus_s.out_valid && !bus_s.out_ready)));
            if (bus_s.out_valid || bus_w.out_valid) begin
               idle = 0;
               if (sb.size() == 0) begin
                  chk("unexpected_out_valid", 1, 0);
               end else begin
                  e = sb[0];
                  chk("sat_valid",  longint'(bus_s.out_valid), 1);
                  chk("wrap_valid", longint'(bus_w.out_valid), 1);
                  chk("sat_acc",    longint'(bus_s.out_acc), e.acc_s);
                  chk("sat_err",    longint'(bus_s.out_err), e.err);
                  chk("sat_flag",   longint'(bus_s.out_sat), e.sat);
                  if (bus_s.out_ready) begin
                     chk("wrap_acc",  longint'(bus_w.out_acc), e.acc_w);
                     chk("wrap_err",  longint'(bus_w.out_err), e.err);
                     chk("wrap_flag", longint'(bus_w.out_sat), 0);
                     void'(sb.pop_front());
                  end
               end
            end else if (sb.size() > 0) begin
               idle++;
               if (idle > 400) begin
                  chk("result_timeout", 0, 1);
                  void'(sb.pop_front());
                  idle = 0;
               end
            end
         end else begin
            idle = 0;
         end
      end
   end

   initial begin
      logic [DW-1:0] one_d, one_w;
      bus_s.in_valid  = 1'b0;
      bus_s.in_last   = 1'b0;
      bus_s.convtypeD = 2'b11;
      bus_s.convtypeW = 2'b11;
      bus_s.d         = '0;
      bus_s.w         = '0;
      rst             = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", longint'(bus_s.out_valid), 0);
      chk("rst_out_acc",   longint'(bus_s.out_acc), 0);
      chk("rst_out_err",   longint'(bus_s.out_err), 0);
      chk("rst_out_sat",   longint'(bus_s.out_sat), 0);
      chk("rst_in_ready",  longint'(bus_s.in_ready), 1);
      chk("rst_wrap_valid", longint'(bus_w.out_valid), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 8x8 single beat, lane0 only; result appears in the third cycle after the beat.
      one_d = '0; one_d[7:0] = 8'hFF;
      one_w = '0; one_w[7:0] = 8'h80;
      send(2'b11, 2'b11, one_d, one_w, 1'b1);
      @(negedge clk); chk("latency_c1", longint'(bus_s.out_valid), 0);
      @(negedge clk); chk("latency_c2", longint'(bus_s.out_valid), 0);
      @(negedge clk); chk("latency_c3", longint'(bus_s.out_valid), 1);
      drain();

      // 2x2 two-beat frame with a bubble, then back-to-back 4x2 frames.
      send(2'b01, 2'b01, rep(8'hFF), rep(8'h55), 1'b0);
      bubble(3);
      send(2'b01, 2'b01, rep(8'hFF), rep(8'h55), 1'b1);
      repeat (3) send(2'b10, 2'b01, rep(8'hFF), rep(8'h33), 1'b1);

      // Saturation / wrap on a two-beat 8x8 frame.
      send(2'b11, 2'b11, rep(8'hFF), rep(8'h80), 1'b0);
      send(2'b11, 2'b11, rep(8'hFF), rep(8'h80), 1'b1);
      drain();

      // Result held with out_ready low while the next frame is pushed in.
      ready_mode = 2;
      send(2'b10, 2'b10, 32'h12345678, 32'h9ABCDEF0, 1'b1);
      fork
         begin
            repeat (9) @(posedge clk);
            ready_mode = 0;
         end
         begin
            send(2'b11, 2'b10, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0);
            send(2'b11, 2'b10, 32'hFFFF0000, 32'h8080FFFF, 1'b0);
            send(2'b11, 2'b10, 32'h01020304, 32'hF0E0D0C0, 1'b1);
         end
      join
      drain();

      // Mode change mid-frame, illegal combinations.
      send(2'b11, 2'b11, 32'hC3C3C3C3, 32'h81FF7F01, 1'b0);
      send(2'b10, 2'b10, 32'h3C3C3C3C, 32'h7E817E81, 1'b1);
      send(2'b10, 2'b11, rep(8'hFF), rep(8'h55), 1'b1);
      send(2'b00, 2'b01, rep(8'hAB), rep(8'hCD), 1'b1);
      drain();

      // Reset with a last beat still in the pipeline: that frame must never appear.
      send(2'b11, 2'b11, rep(8'h11), rep(8'h22), 1'b0);
      send(2'b11, 2'b11, rep(8'h33), rep(8'h44), 1'b1);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      sb.delete();
      m_in_frame = 0;
      #1;
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("post_rst_no_valid", longint'(bus_s.out_valid), 0);
         chk("post_rst_acc", longint'(bus_s.out_acc), 0);
      end
      @(posedge clk);
      #1;
      send(2'b10, 2'b01, rep(8'hFF), rep(8'h33), 1'b1);
      drain();

      ready_mode = 1;
      for (int f = 0; f < 150; f++) rand_frame();
      ready_mode = 0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
